// File: rtl/range_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : range_burst_ctrl
// Purpose  : Frames a programmable-length burst of samples from a valid/ready
//            stream and sequences a min/max range-finder datapath. It pulses
//            go with the first sample and finish one cycle after the last.
//            It then holds the captured range behind a valid/ready result port.
// Ports    : clock, reset      - clock / synchronous active-high reset
//            start, cfg_len    - burst request and its length (sampled in IDLE)
//            in_data/in_valid/in_ready - sample stream
//            rf_data/rf_go/rf_finish/rf_range - datapath interface
//            res_range/res_valid/res_ready/res_partial - result port
//            busy, err_len     - status (err_len sticky until reset)
// Options  : RANGE_TIMEOUT_EN  - when defined, a burst that sees TIMEOUT idle
//            cycles in STREAM finishes early and flags res_partial.
// Revision : 1.0 - initial release
// ============================================================================
module range_burst_ctrl #(
    parameter int WIDTH   = 16,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    output logic [WIDTH-1:0] res_range,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_partial,
    output logic             busy,
    output logic             err_len
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_STREAM = 3'd2,
        S_FINISH = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_count;
    logic [LEN_W-1:0]   w_count_inc;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_res_range;
    logic               r_res_valid;
    logic               r_err_len;
    logic               w_accept;
    logic               w_hs;
    logic               w_timeout;

    // Acceptance depends only on state so the handshake never loops back
    // through the next-state logic.
    assign w_accept    = (r_state == S_FIRST) || (r_state == S_STREAM);
    assign w_hs        = in_valid && w_accept;
    assign w_count_inc = r_count + LEN_W'(1);

    assign in_ready  = w_accept;
    // Held sample keeps the datapath comparing a value it has already seen,
    // so idle gaps inside a burst cannot disturb min/max.
    assign rf_data   = w_hs ? in_data : r_data;
    assign res_range = r_res_range;
    assign res_valid = r_res_valid;
    assign busy      = (r_state != S_IDLE);
    assign err_len   = r_err_len;

`ifdef RANGE_TIMEOUT_EN
    localparam int C_IDLE_W = $clog2(TIMEOUT + 1);

    logic [C_IDLE_W-1:0] r_idle;
    logic                r_forced;
    logic                r_res_partial;

    // Fires on the TIMEOUT-th consecutive cycle without a handshake.
    assign w_timeout   = (r_state == S_STREAM) && !w_hs &&
                         (r_idle == C_IDLE_W'(TIMEOUT - 1));
    assign res_partial = r_res_partial;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idle        <= '0;
            r_forced      <= 1'b0;
            r_res_partial <= 1'b0;
        end else begin
            if ((r_state != S_STREAM) || w_hs) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + C_IDLE_W'(1);
            end

            if (w_timeout) begin
                r_forced <= 1'b1;
            end else if (r_state == S_FINISH) begin
                r_res_partial <= r_forced;
                r_forced      <= 1'b0;
            end else if ((r_state == S_HOLD) && res_ready) begin
                r_res_partial <= 1'b0;
            end
        end
    end
`else
    // Folds to 0; keeps TIMEOUT referenced when the feature is compiled out.
    localparam logic C_NO_PARTIAL = (TIMEOUT < 0);

    assign w_timeout   = 1'b0;
    assign res_partial = C_NO_PARTIAL;
`endif

    // Next-state and datapath strobes.
    always_comb begin
        w_state_next = r_state;
        rf_go        = 1'b0;
        rf_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (cfg_len != '0)) begin
                    w_state_next = S_FIRST;
                end
            end
            S_FIRST: begin
                rf_go = in_valid;
                if (in_valid) begin
                    w_state_next = (r_len == LEN_W'(1)) ? S_FINISH : S_STREAM;
                end
            end
            S_STREAM: begin
                if (in_valid && (w_count_inc == r_len)) begin
                    w_state_next = S_FINISH;
                end else if (w_timeout) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                rf_finish    = 1'b1;
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_res_range <= '0;
            r_res_valid <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if ((r_state == S_IDLE) && start) begin
                if (cfg_len == '0) begin
                    r_err_len <= 1'b1;
                end else begin
                    r_len   <= cfg_len;
                    r_count <= '0;
                end
            end

            if (w_hs) begin
                r_data  <= in_data;
                r_count <= w_count_inc;
            end

            if (r_state == S_FINISH) begin
                r_res_range <= rf_range;
                r_res_valid <= 1'b1;
            end else if ((r_state == S_HOLD) && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_range_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_range_burst_ctrl
// Purpose  : Self-checking bench for range_burst_ctrl. Stimulus pushes the
//            expected result of each burst into a queue. A separate monitor
//            pops it when the result port hands a value over. A small
//            behavioural min/max datapath closes the rf_* loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_range_burst_ctrl;

    localparam int WIDTH   = 16;
    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 8;

    logic             clock;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rf_data;
    logic             rf_go;
    logic             rf_finish;
    logic [WIDTH-1:0] rf_range;
    logic [WIDTH-1:0] res_range;
    logic             res_valid;
    logic             res_ready;
    logic             res_partial;
    logic             busy;
    logic             err_len;

    range_burst_ctrl #(
        .WIDTH   (WIDTH),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .cfg_len     (cfg_len),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rf_data     (rf_data),
        .rf_go       (rf_go),
        .rf_finish   (rf_finish),
        .rf_range    (rf_range),
        .res_range   (res_range),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_partial (res_partial),
        .busy        (busy),
        .err_len     (err_len)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural range-finder datapath: go loads, otherwise min/max track.
    logic [WIDTH-1:0] dp_min, dp_max;
    always @(posedge clock) begin
        if (reset) begin
            dp_min <= '0;
            dp_max <= '0;
        end else if (rf_go) begin
            dp_min <= rf_data;
            dp_max <= rf_data;
        end else begin
            if (rf_data < dp_min) dp_min <= rf_data;
            if (rf_data > dp_max) dp_max <= rf_data;
        end
    end
    assign rf_range = dp_max - dp_min;

    int checks = 0;
    int errors = 0;
    int last_hs = 0;
    logic [WIDTH:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares each accepted result against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {15'd0, res_partial, res_range}, 32'hFFFF_FFFF);
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    chk("res_range", {16'd0, res_range}, {16'd0, e[WIDTH-1:0]});
                    chk("res_partial", {31'd0, res_partial}, {31'd0, e[WIDTH]});
                end
            end
            if (rf_go || rf_finish) begin
                chk("go_finish_exclusive", {31'd0, rf_go && rf_finish}, 32'd0);
            end
        end
    end

    // All stimulus tasks start and end at negedge+1.
    task automatic start_burst(input logic [LEN_W-1:0] len);
        start   = 1'b1;
        cfg_len = len;
        @(negedge clock);
        start = 1'b0;
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int gap, input bit first);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clock);
            #1;
            w++;
        end
        if (!in_ready) chk("in_ready_wait", 32'd0, 32'd1);
        chk("rf_go", {31'd0, rf_go}, {31'd0, first});
        chk("rf_data_hs", {16'd0, rf_data}, {16'd0, d});
        last_hs = cyc;
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = ~d;
        #1;
        for (int g = 0; g < gap; g++) begin
            chk("rf_data_held", {16'd0, rf_data}, {16'd0, d});
            @(negedge clock);
            #1;
        end
    endtask

    // Called in the cycle right after the last handshake.
    task automatic check_latency();
        chk("finish_lat_cycle", cyc, last_hs + 1);
        chk("finish_lat", {31'd0, rf_finish}, 32'd1);
        chk("no_go_at_finish", {31'd0, rf_go}, 32'd0);
        chk("in_ready_finish", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        #1;
        chk("valid_lat", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 50) begin
            @(negedge clock);
            #1;
            w++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cfg_len   = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outputs", {27'd0, in_ready, rf_go, rf_finish, res_valid, res_partial}, 32'd0);
        chk("rst_res_range", {16'd0, res_range}, 32'd0);
        chk("rst_rf_data", {16'd0, rf_data}, 32'd0);
        chk("rst_err_len", {31'd0, err_len}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        #1;

        // Burst 1: back-to-back samples, range 25-3.
        exp_q.push_back({1'b0, 16'd22});
        start_burst(8'd4);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        send(16'd10, 0, 1'b1);
        send(16'd3,  0, 1'b0);
        send(16'd25, 0, 1'b0);
        send(16'd7,  0, 1'b0);
        check_latency();
        wait_idle();

        // Burst 2: gaps between samples, range 9-1.
        exp_q.push_back({1'b0, 16'd8});
        start_burst(8'd4);
        send(16'd5, 2, 1'b1);
        send(16'd9, 2, 1'b0);
        send(16'd1, 2, 1'b0);
        send(16'd6, 0, 1'b0);
        check_latency();
        wait_idle();

        // Burst 3: single sample, result back-pressured, start ignored in HOLD.
        res_ready = 1'b0;
        exp_q.push_back({1'b0, 16'd0});
        start_burst(8'd1);
        send(16'd42, 0, 1'b1);
        check_latency();
        start   = 1'b1;
        cfg_len = 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_range", {16'd0, res_range}, 32'd0);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clock);
        #1;
        chk("release_valid", {31'd0, res_valid}, 32'd0);
        chk("release_busy", {31'd0, busy}, 32'd0);

        // Zero-length start flags err_len and stays idle.
        start_burst(8'd0);
        chk("err_len_set", {31'd0, err_len}, 32'd1);
        chk("err_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back({1'b0, 16'd0});
        start_burst(8'd2);
        send(16'd4, 0, 1'b1);
        send(16'd4, 0, 1'b0);
        check_latency();
        wait_idle();
        chk("err_len_sticky", {31'd0, err_len}, 32'd1);

        // Reset after two of four samples: burst dropped.
        start_burst(8'd4);
        send(16'd50, 0, 1'b1);
        send(16'd60, 0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        #1;
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_err_len", {31'd0, err_len}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_finish", {31'd0, rf_finish}, 32'd0);
            @(negedge clock);
            #1;
        end
        exp_q.push_back({1'b0, 16'd1});
        start_burst(8'd2);
        send(16'd1, 0, 1'b1);
        send(16'd2, 0, 1'b0);
        check_latency();
        wait_idle();

`ifdef RANGE_TIMEOUT_EN
        // Two of four samples then silence: forced finish after TIMEOUT idle cycles.
        begin
            int w;
            exp_q.push_back({1'b1, 16'd8});
            start_burst(8'd4);
            send(16'd3,  0, 1'b1);
            send(16'd11, 0, 1'b0);
            w = 0;
            while (!rf_finish && w < 30) begin
                @(negedge clock);
                #1;
                w++;
            end
            chk("timeout_finish_cycle", cyc, last_hs + TIMEOUT + 1);
            @(negedge clock);
            #1;
            chk("timeout_valid", {31'd0, res_valid}, 32'd1);
            chk("timeout_partial", {31'd0, res_partial}, 32'd1);
            wait_idle();
            chk("partial_cleared", {31'd0, res_partial}, 32'd0);
        end
`endif

        repeat (3) @(negedge clock);
        #3;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
